uart_rx_fifo: RTL

//   Receive-side byte buffer directly downstream of the UART receiver (9600 baud, 8 data bits + even parity).

---
 rtl/uart_rx_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Each rising edge of read_complete offers one byte. Bytes with a parity
// error are either dropped or stored with their error flag, depending on
// DROP_ERR. Sticky overflow and a saturating parity-error counter record
// what the consumer could not see directly.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DROP_ERR  = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 read_complete,
    input  logic [7:0]           read_value,
    input  logic                 read_error,
    input  logic                 pop,
    input  logic                 clear_stats,
    output logic [7:0]           dout,
    output logic                 dout_err,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic                 DROP    = (DROP_ERR != 0);
    localparam logic [ADDR_W:0]      PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    // Storage. It is never reset; only the pointers define what is valid.
    logic [7:0] data_mem [DEPTH];
    logic       err_mem  [DEPTH];

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    logic rc_q;
    logic push_req;
    logic drop_bad;
    logic push_ok;
    logic pop_ok;
    logic overflow_evt;
    logic error_evt;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_idx == wr_idx) && (rd_ptr[ADDR_W] != wr_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // A level on read_complete counts only once, at its rising edge.
    assign push_req = read_complete & ~rc_q;

    // A byte with a parity error never reaches the memory when dropping is enabled.
    assign drop_bad = DROP & read_error;

    // When full, a same-cycle pop frees the slot the incoming byte needs.
    assign push_ok = push_req & ~drop_bad & (~full | pop);

    // A pop on an empty FIFO is ignored. When a push and a pop arrive together
    // on an empty FIFO, only the push takes effect.
    assign pop_ok = pop & ~empty;

    // A byte is lost only when it would have been stored but no slot was free.
    assign overflow_evt = push_req & ~drop_bad & full & ~pop;
    assign error_evt    = push_req & read_error;

    // The head entry falls through to the outputs. Its error flag reads 0
    // while empty, so it is defined after reset even though the memory is not.
    assign dout     = data_mem[rd_idx];
    assign dout_err = DROP ? 1'b0 : (~empty & err_mem[rd_idx]);

    // Edge register. It still loads during reset, so a level that is high when
    // reset is released does not count as a new byte.
    always_ff @(posedge clk_50M) begin
        rc_q <= read_complete;
    end

    // Write and read pointers.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Memory write port: the byte and its error flag go into the slot at wr_ptr.
    always_ff @(posedge clk_50M) begin
        if (push_ok && !reset) begin
            data_mem[wr_idx] <= read_value;
            err_mem[wr_idx]  <= read_error;
        end
    end

    // Sticky overflow flag. clear_stats wins over an overflow in the same cycle.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clear_stats) begin
            overflow <= 1'b0;
        end else if (overflow_evt) begin
            overflow <= 1'b1;
        end
    end

    // Saturating parity-error counter. clear_stats wins over an error in the same cycle.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            err_count <= '0;
        end else if (clear_stats) begin
            err_count <= '0;
        end else if (error_evt && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
        end
    end

endmodule
